rr_mux_nbit: RTL and testbench
==============================

RR_MUX_NBIT -- requirements
Module: rr_mux_nbit

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning data width per channel in bits (N >= 1).
REQ-002 The block SHALL have parameter CH, default 4, meaning number of input channels (CH >= 2).
REQ-003 The block SHALL have parameter MODE, default 1, meaning 0 = fixed select by s, 1 = round-robin arbitration.
REQ-004 The block SHALL use localparam SW = $clog2(CH) for select, pointer and channel-index widths.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have port x, input, N*CH, flattened channel data, where channel i occupies x[i*N +: N].
REQ-008 The block SHALL have port x_valid, input, CH, with bit i meaning channel i offers data.
REQ-009 The block SHALL have port x_ready, output, CH, with bit i meaning channel i data is accepted this cycle.
REQ-010 The block SHALL have port s, input, SW, the channel select, used only when MODE = 0.
REQ-011 The block SHALL have port z, output, N, registered selected data.
REQ-012 The block SHALL have port z_valid, output, 1, meaning z holds valid data.
REQ-013 The block SHALL have port z_ready, input, 1, meaning the downstream accepts z this cycle.
REQ-014 The block SHALL have port z_ch, output, SW, the channel index that produced the current z.

Function
REQ-015 The block SHALL compute load = (~z_valid | z_ready) & rst_n; a transfer from channel g occurs when load & grant_valid.
REQ-016 When MODE = 0, the block SHALL set grant g = s, with grant_valid = x_valid[s] & (s < CH).
REQ-017 When MODE = 1, the block SHALL choose g as the first index with x_valid set, searching ptr, ptr+1, ..., CH-1, 0, ..., ptr-1; grant_valid = |x_valid.
REQ-018 On a transfer, the block SHALL register z <= x[g*N +: N], z_valid <= 1 and z_ch <= g on the next rising edge, giving 1-cycle latency.
REQ-019 On a transfer in MODE 1, the block SHALL update ptr <= (g == CH-1) ? 0 : g+1, wrapping at CH-1 for non-power-of-2 CH.
REQ-020 The block SHALL leave ptr unchanged on any cycle without a transfer, and SHALL keep ptr at 0 in MODE 0.
REQ-021 The block SHALL drive x_ready combinationally, one-hot at bit g when a transfer occurs and all-zero otherwise.
REQ-022 When z_ready = 1 and no transfer occurs, the block SHALL clear z_valid to 0 on the next edge while z and z_ch hold.
REQ-023 When z_valid = 1 and z_ready = 0, the block SHALL hold z, z_ch and z_valid stable and drive x_ready all-zero (backpressure).
REQ-024 When z_valid = 1, z_ready = 1 and a grant is available in the same cycle, the block SHALL load the new data with no bubble, sustaining 1 transfer per cycle.
REQ-025 The block SHALL not reorder, duplicate or drop data: each x_ready pulse corresponds to exactly one later z_valid & z_ready beat.
REQ-026 In MODE 0, a change of s while z is stalled SHALL not affect z; the new s applies from the next transfer.

Reset
REQ-027 When rst_n = 0 at a rising edge, the block SHALL set z = 0, z_valid = 0, z_ch = 0 and ptr = 0.
REQ-028 While rst_n = 0, the block SHALL force x_ready to all-zero regardless of other inputs.
REQ-029 Reset asserted mid-stall SHALL discard the held beat; the first post-reset grant in MODE 1 SHALL search from channel 0.

Verification
REQ-030 Reset test: rst_n = 0 for 2 cycles with x_valid = 1111 and z_ready = 1 -> x_ready = 0000, z = 0, z_valid = 0, z_ch = 0.
REQ-031 Fixed-select test: MODE 0, s = 2, x_valid = 0100, channel 2 data = 4'hA, z_ready = 1 -> x_ready = 0100 in the same cycle, then z = 4'hA, z_valid = 1 and z_ch = 2 on the next cycle.
REQ-032 Round-robin fairness test: MODE 1, x_valid = 1111 held, z_ready = 1, channel data = 1,2,3,4 -> z_ch = 0,1,2,3,0,... and z = 1,2,3,4,1,... on consecutive cycles.
REQ-033 Round-robin wrap test: MODE 1, ptr = 1, x_valid = 1001 -> grant to channel 3, then ptr = 0 and the next grant goes to channel 0.
REQ-034 Backpressure test: z_valid = 1, z_ready = 0 for 5 cycles with inputs changing -> x_ready = 0000 and z, z_ch stable throughout; on z_ready = 1, the new beat loads in the same cycle.
REQ-035 Mid-operation reset test: during a stall with z_valid = 1, assert rst_n = 0 for 1 cycle -> z_valid = 0 and ptr = 0; with x_valid = 1111 afterwards, the first grant goes to channel 0.

Source files
------------

// File: rtl/rr_mux_nbit.sv
// rr_mux_nbit: N-bit, CH-channel multiplexer with a registered output stage.
// MODE 0 routes the channel named by s. MODE 1 picks a channel by round-robin.
// Each input and the output use a valid/ready handshake. The output register
// holds one beat. It reloads in the same cycle it drains, so it can accept one
// transfer per cycle. While it is stalled, every x_ready bit stays low.
module rr_mux_nbit #(
  parameter  int N    = 4,
  parameter  int CH   = 4,
  parameter  int MODE = 1,
  localparam int SW   = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*CH-1:0] x,
  input  logic [CH-1:0]   x_valid,
  output logic [CH-1:0]   x_ready,
  input  logic [SW-1:0]   s,
  output logic [N-1:0]    z,
  output logic            z_valid,
  input  logic            z_ready,
  output logic [SW-1:0]   z_ch
);

  // Output stage and arbitration pointer.
  logic [N-1:0]  r_z;
  logic          r_z_valid;
  logic [SW-1:0] r_z_ch;
  logic [SW-1:0] r_ptr;

  // The grant decision and the data it selects.
  logic [SW-1:0] w_grant;
  logic          w_grant_valid;
  logic [N-1:0]  w_grant_data;
  logic          w_load;
  logic          w_xfer;
  logic [SW-1:0] w_ptr_next;

  // The output register can take a beat when it is empty or draining this cycle.
  // A low rst_n blocks every transfer, so no upstream beat is lost to reset.
  assign w_load = (~r_z_valid | z_ready) & rst_n;
  assign w_xfer = w_load & w_grant_valid;

  // Grant selection: fixed by s in MODE 0, rotating priority from r_ptr in MODE 1.
  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_grant       = '0;
    w_grant_valid = 1'b0;
    if (MODE == 0) begin
      // Match s against each real channel. An s value of CH or more matches
      // nothing, so it never grants.
      w_grant = s;
      for (int c = 0; c < CH; c++) begin
        if (s == SW'(c)) w_grant_valid = x_valid[c];
      end
    end else begin
      // Walk the offsets from farthest to nearest, so the nearest requester to
      // r_ptr is the last one written. The wrap uses subtraction, which also
      // works when CH is not a power of two.
      for (int k = CH - 1; k >= 0; k--) begin
        int idx;
        idx = int'(r_ptr) + k;
        if (idx >= CH) idx = idx - CH;
        if (x_valid[idx[SW-1:0]]) begin
          w_grant       = idx[SW-1:0];
          w_grant_valid = 1'b1;
        end
      end
    end
  end

  // Pick the data of the granted channel. The part-select bases are constants.
  always_comb begin
    w_grant_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (w_grant == SW'(c)) w_grant_data = x[c*N +: N];
    end
  end

  // One-hot accept for the granted channel, only on a real transfer.
  always_comb begin
    x_ready = '0;
    for (int c = 0; c < CH; c++) begin
      x_ready[c] = w_xfer & (w_grant == SW'(c));
    end
  end

  // Next pointer: the channel after the winner, wrapping at CH-1.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_xfer) begin
      if (w_grant == SW'(CH - 1)) w_ptr_next = '0;
      else                        w_ptr_next = w_grant + SW'(1);
    end
  end

  // Output register: load on transfer, empty when drained without a new beat.
  // NOTE: registered state uses non-blocking assignments, so every flop here
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_z       <= '0;
      r_z_valid <= 1'b0;
      r_z_ch    <= '0;
    end else if (w_xfer) begin
      r_z       <= w_grant_data;
      r_z_valid <= 1'b1;
      r_z_ch    <= w_grant;
    end else if (z_ready) begin
      r_z_valid <= 1'b0;
    end
  end

  // Round-robin pointer. It moves only on a transfer and stays 0 in MODE 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (MODE != 0) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign z       = r_z;
  assign z_valid = r_z_valid;
  assign z_ch    = r_z_ch;

endmodule

// File: tb/tb_rr_mux_nbit.sv
// Bench for rr_mux_nbit. It drives one round-robin instance and one
// fixed-select instance from the same inputs. A small reference model of the
// round-robin instance predicts x_ready on every cycle. It also queues the
// expected {channel, data} for each accepted beat, and compares the queue
// entry when the output handshake completes. Directed checks cover reset,
// fixed select, fairness, wrap, backpressure and reset during a stall.
module tb_rr_mux_nbit;
  localparam int N  = 4;
  localparam int CH = 4;
  localparam int SW = $clog2(CH);

  logic            clk;
  logic            rst_n;
  logic [N*CH-1:0] x;
  logic [CH-1:0]   x_valid;
  logic [SW-1:0]   s;
  logic            z_ready;

  logic [CH-1:0]   rr_x_ready, fx_x_ready;
  logic [N-1:0]    rr_z, fx_z;
  logic            rr_z_valid, fx_z_valid;
  logic [SW-1:0]   rr_z_ch, fx_z_ch;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for the round-robin instance.
  logic            m_zv;
  int              m_ptr;
  logic            m_xfer;
  int              m_g;
  logic [SW+N-1:0] sb_q[$];

  rr_mux_nbit #(.N(N), .CH(CH), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(rr_x_ready),
    .s(s), .z(rr_z), .z_valid(rr_z_valid), .z_ready(z_ready), .z_ch(rr_z_ch)
  );

  rr_mux_nbit #(.N(N), .CH(CH), .MODE(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(fx_x_ready),
    .s(s), .z(fx_z), .z_valid(fx_z_valid), .z_ready(z_ready), .z_ch(fx_z_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Negative edge: inputs are stable. Predict and compare handshakes, and pop
  // the scoreboard entry for a completed output beat.
  task automatic at_neg();
    logic [SW+N-1:0] e;
    logic [CH-1:0]   exp_rdy;
    @(negedge clk);
    check("rr_zvalid", rr_z_valid, m_zv);
    if (m_zv && z_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_ch", rr_z_ch, e[SW+N-1:N]);
        check("sb_data", rr_z, e[N-1:0]);
      end
    end
    m_xfer = 1'b0;
    m_g    = 0;
    if (rst_n && (!m_zv || z_ready)) begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (m_ptr + k) % CH;
        if (!m_xfer && x_valid[c]) begin
          m_xfer = 1'b1;
          m_g    = c;
        end
      end
    end
    exp_rdy = '0;
    if (m_xfer) begin
      exp_rdy[m_g] = 1'b1;
      sb_q.push_back({SW'(m_g), x[m_g*N +: N]});
    end
    check("rr_x_ready", rr_x_ready, exp_rdy);
  endtask

  // Just after the rising edge: advance the model.
  task automatic at_pos();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_zv  = 1'b0;
      m_ptr = 0;
      sb_q.delete();
    end else if (m_xfer) begin
      m_zv  = 1'b1;
      m_ptr = (m_g == CH - 1) ? 0 : m_g + 1;
    end else if (z_ready) begin
      m_zv = 1'b0;
    end
  endtask

  task automatic step();
    at_neg();
    at_pos();
  endtask

  initial begin
    m_zv    = 1'b0;
    m_ptr   = 0;
    rst_n   = 1'b0;
    x       = {4'h4, 4'h3, 4'h2, 4'h1};
    x_valid = 4'b1111;
    z_ready = 1'b1;
    s       = '0;

    // Reset for two cycles with every channel requesting.
    at_neg();
    check("rst_fx_x_ready", fx_x_ready, 4'b0000);
    at_pos();
    step();
    check("rst_z", rr_z, 0);
    check("rst_zvalid", rr_z_valid, 0);
    check("rst_zch", rr_z_ch, 0);
    check("rst_fx_zvalid", fx_z_valid, 0);

    // Fairness: all channels requesting, so the output visits 0,1,2,3,0,...
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      check("fair_ch", rr_z_ch, k % 4);
      check("fair_z", rr_z, (k % 4) + 1);
    end

    // Wrap: ptr is 1 and only channels 0 and 3 request, so 3 wins, then 0.
    x_valid = 4'b1001;
    step();
    check("wrap_ch3", rr_z_ch, 3);
    check("wrap_z4", rr_z, 4);
    step();
    check("wrap_ch0", rr_z_ch, 0);
    check("wrap_z1", rr_z, 1);

    // Backpressure: the output holds channel 0 data 1 while the inputs change.
    z_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      x       = $urandom;
      x_valid = 4'($urandom_range(1, 15));
      at_neg();
      check("bp_x_ready", rr_x_ready, 4'b0000);
      at_pos();
      check("bp_z", rr_z, 1);
      check("bp_zch", rr_z_ch, 0);
      check("bp_zvalid", rr_z_valid, 1);
    end
    x       = {4'h4, 4'h3, 4'h2, 4'h1};
    x_valid = 4'b1111;
    z_ready = 1'b1;
    at_neg();
    check("bp_release_ready", rr_x_ready, 4'b0010);
    at_pos();
    check("bp_release_ch", rr_z_ch, 1);
    check("bp_release_z", rr_z, 2);

    // Reset during a stall drops the held beat. The search restarts at channel 0.
    z_ready = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mrst_zvalid", rr_z_valid, 0);
    check("mrst_z", rr_z, 0);
    check("mrst_zch", rr_z_ch, 0);
    rst_n   = 1'b1;
    z_ready = 1'b1;
    step();
    check("mrst_first_ch", rr_z_ch, 0);
    check("mrst_first_z", rr_z, 1);

    // Fixed select: empty both outputs, then route channel 2.
    x_valid = 4'b0000;
    step();
    check("fx_empty", fx_z_valid, 0);
    s       = 2'd2;
    x       = {4'h4, 4'hA, 4'h2, 4'h1};
    x_valid = 4'b0100;
    at_neg();
    check("fx_x_ready", fx_x_ready, 4'b0100);
    at_pos();
    check("fx_z", fx_z, 4'hA);
    check("fx_zvalid", fx_z_valid, 1);
    check("fx_zch", fx_z_ch, 2);

    // Changing s during a stall must not disturb the held beat.
    z_ready = 1'b0;
    s       = 2'd1;
    x       = {4'h4, 4'hA, 4'h5, 4'h1};
    x_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      check("fx_stall_ready", fx_x_ready, 4'b0000);
      at_pos();
      check("fx_stall_z", fx_z, 4'hA);
      check("fx_stall_zch", fx_z_ch, 2);
    end
    z_ready = 1'b1;
    at_neg();
    check("fx_resume_ready", fx_x_ready, 4'b0010);
    at_pos();
    check("fx_resume_z", fx_z, 4'h5);
    check("fx_resume_zch", fx_z_ch, 1);

    // Random traffic checked against the round-robin scoreboard.
    for (int k = 0; k < 300; k++) begin
      x       = $urandom;
      x_valid = 4'($urandom_range(0, 15));
      z_ready = ($urandom_range(0, 3) != 0);
      s       = 2'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
